// File: rtl/spike_dec_pkg.sv
// spike_dec_pkg: shared burst FSM states, counter widths and window length mapping
package spike_dec_pkg;
  localparam int ISI_W   = 8;
  localparam int WIN_W   = 7;
  localparam int RATE_W  = 8;
  localparam int STATE_W = 6;
  localparam int RUN_W   = 8;
  typedef enum logic [1:0] {QUIET, ARMING, BURST} burst_state_e;
  function automatic logic [WIN_W-1:0] win_last(input logic [1:0] sel);
    return WIN_W'((16 << sel) - 1);
  endfunction
endpackage

// File: rtl/isi_timer.sv
// isi_timer: spike edge detector with saturating inter-spike interval counter
module isi_timer
  import spike_dec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  output logic             edge_out,
  output logic [ISI_W-1:0] interval,
  output logic             interval_valid
);
  logic prev_q, prev_d, first_q, first_d;
  logic [ISI_W-1:0] tmr_q, tmr_d;
  // timer reads 1 the cycle after an edge, so at the next edge it holds the interval
  always_comb begin
    edge_out       = spike_in & ~prev_q;
    interval       = tmr_q;
    interval_valid = edge_out & ~first_q;
    prev_d         = spike_in;
    first_d        = first_q & ~edge_out;
    tmr_d          = edge_out ? ISI_W'(1) : tmr_q + ISI_W'(~&tmr_q);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      first_q <= 1'b1;
      tmr_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
      tmr_q   <= tmr_d;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike rate/peak reporting, inter-spike interval and burst detection
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int BURST_ISI = 4,
  parameter int BURST_N   = 3,
  parameter int BURST_GAP = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               spike_in,
  input  logic [STATE_W-1:0] state_in,
  input  logic [1:0]         win_sel,
  output logic [RATE_W-1:0]  rate_out,
  output logic [STATE_W-1:0] peak_out,
  output logic               rate_valid,
  output logic [ISI_W-1:0]   isi_out,
  output logic               isi_valid,
  output logic               burst
);
  logic edge_det, int_valid, win_end, short_isi;
  logic [ISI_W-1:0] interval, isi_q, isi_d;
  logic [WIN_W-1:0] win_q, win_d, last_q, last_d;
  logic [RATE_W-1:0] cnt_q, cnt_d, cnt_now, rate_q, rate_d;
  logic [STATE_W-1:0] pk_q, pk_d, pk_now, peak_q, peak_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic rv_q, rv_d, iv_q, iv_d, burst_q, burst_d;
  burst_state_e st_q, st_d;

  isi_timer u_isi (
    .clk            (clk),
    .reset          (reset),
    .spike_in       (spike_in),
    .edge_out       (edge_det),
    .interval       (interval),
    .interval_valid (int_valid)
  );

  // window accumulators; the last window cycle's edge and state close out that window
  always_comb begin
    win_end = win_q == last_q;
    cnt_now = cnt_q + RATE_W'(edge_det);
    pk_now  = state_in > pk_q ? state_in : pk_q;
    win_d   = win_end ? '0 : win_q + 1'b1;
    last_d  = win_end ? win_last(win_sel) : last_q;
    cnt_d   = win_end ? '0 : cnt_now;
    pk_d    = win_end ? '0 : pk_now;
    rate_d  = win_end ? cnt_now : rate_q;
    peak_d  = win_end ? pk_now : peak_q;
    rv_d    = win_end;
  end

  // interval reporting and burst FSM; BURST drops BURST_GAP cycles after the last edge
  always_comb begin
    isi_d     = int_valid ? interval : isi_q;
    iv_d      = int_valid;
    short_isi = interval <= ISI_W'(BURST_ISI);
    run_inc   = run_q + 1'b1;
    st_d      = st_q;
    run_d     = run_q;
    if (st_q == BURST)
      st_d = (!edge_det && interval >= ISI_W'(BURST_GAP - 1)) ? QUIET : BURST;
    else if (int_valid) begin
      st_d  = !short_isi ? QUIET : (run_inc >= RUN_W'(BURST_N) ? BURST : ARMING);
      run_d = st_d == ARMING ? run_inc : '0;
    end
    burst_d = st_d == BURST;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= '0;
      last_q  <= win_last(win_sel);
      cnt_q   <= '0;
      pk_q    <= '0;
      rate_q  <= '0;
      peak_q  <= '0;
      rv_q    <= 1'b0;
      isi_q   <= '0;
      iv_q    <= 1'b0;
      run_q   <= '0;
      st_q    <= QUIET;
      burst_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pk_q    <= pk_d;
      rate_q  <= rate_d;
      peak_q  <= peak_d;
      rv_q    <= rv_d;
      isi_q   <= isi_d;
      iv_q    <= iv_d;
      run_q   <= run_d;
      st_q    <= st_d;
      burst_q <= burst_d;
    end
  end

  assign rate_out   = rate_q;
  assign peak_out   = peak_q;
  assign rate_valid = rv_q;
  assign isi_out    = isi_q;
  assign isi_valid  = iv_q;
  assign burst      = burst_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed checks of rate windows, intervals and burst detection
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic reset, spike_in;
  logic [5:0] state_in;
  logic [1:0] win_sel;
  logic [7:0] rate_out, isi_out;
  logic [5:0] peak_out;
  logic rate_valid, isi_valid, burst;
  int n_chk = 0, n_err = 0, n_rv = 0, n_iv = 0;

  spike_rate_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .state_in   (state_in),
    .win_sel    (win_sel),
    .rate_out   (rate_out),
    .peak_out   (peak_out),
    .rate_valid (rate_valid),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid),
    .burst      (burst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic step(input logic s, input logic [5:0] st);
    spike_in = s;
    state_in = st;
    @(negedge clk);
    if (rate_valid) n_rv++;
    if (isi_valid) n_iv++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spike_in = 1'b0;
    state_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_rv = 0;
    n_iv = 0;
  endtask

  initial begin
    win_sel = 2'd0;
    // rate over a 16-cycle window, plus reset state
    do_reset();
    chk("rst_rate", rate_out, 0);
    chk("rst_peak", peak_out, 0);
    chk("rst_isi", isi_out, 0);
    chk("rst_rv", rate_valid, 0);
    chk("rst_iv", isi_valid, 0);
    chk("rst_burst", burst, 0);
    for (int k = 0; k < 16; k++) begin
      step(k == 2 || k == 5 || k == 15, k == 3 ? 6'd33 : 6'(k));
      if (k == 5) begin
        chk("a_iv6", isi_valid, 1);
        chk("a_isi6", isi_out, 3);
      end
    end
    chk("a_rv", rate_valid, 1);
    chk("a_rate", rate_out, 3);
    chk("a_peak", peak_out, 33);
    chk("a_iv16", isi_valid, 1);
    chk("a_isi16", isi_out, 10);
    chk("a_nrv", n_rv, 1);
    step(0, 0);
    chk("a_rv_pulse", rate_valid, 0);
    chk("a_burst", burst, 0);
    // held-high spike is one edge
    do_reset();
    for (int k = 0; k < 16; k++) step(k >= 3 && k <= 12, 0);
    chk("b_rv", rate_valid, 1);
    chk("b_rate", rate_out, 1);
    chk("b_niv", n_iv, 0);
    // interval of 7, then saturated interval
    do_reset();
    for (int k = 0; k < 18; k++) step(k == 10 || k == 17, 0);
    chk("c_iv", isi_valid, 1);
    chk("c_isi7", isi_out, 7);
    for (int k = 18; k < 318; k++) step(k == 317, 0);
    chk("c_iv_sat", isi_valid, 1);
    chk("c_isi_sat", isi_out, 255);
    chk("c_niv", n_iv, 2);
    chk("c_burst", burst, 0);
    // burst entry on 3rd short interval and exit 16 cycles after last edge
    do_reset();
    for (int k = 0; k < 11; k++) begin
      step(k == 1 || k == 4 || k == 7 || k == 10, 0);
      if (k == 7) begin
        chk("d_iv8", isi_valid, 1);
        chk("d_burst8", burst, 0);
      end
    end
    chk("d_iv11", isi_valid, 1);
    chk("d_isi11", isi_out, 3);
    chk("d_burst11", burst, 1);
    for (int k = 11; k < 26; k++) begin
      step(0, 0);
      if (k == 24) chk("d_burst25", burst, 1);
    end
    chk("d_burst26", burst, 0);
    // peak tracking and win_sel latched only at window boundaries
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) win_sel = 2'd3;
      step(0, k <= 8 ? 6'(5 * k) : 6'(80 - 5 * k));
    end
    chk("e_rv16", rate_valid, 1);
    chk("e_peak40", peak_out, 40);
    chk("e_rate0", rate_out, 0);
    for (int k = 16; k < 144; k++) begin
      step(k == 16 || k == 20 || k == 143, k == 16 ? 6'd9 : (k == 143 ? 6'd7 : 6'd0));
      if (k == 16) chk("e_rv17", rate_valid, 0);
      if (k == 142) chk("e_nrv143", n_rv, 1);
    end
    chk("e_rv144", rate_valid, 1);
    chk("e_rate144", rate_out, 3);
    chk("e_peak144", peak_out, 9);
    // reset mid-window discards partial count
    win_sel = 2'd0;
    do_reset();
    for (int k = 0; k < 9; k++) step(k == 1 || k == 3 || k == 5 || k == 7, 0);
    chk("f_burst_pre", burst, 1);
    reset = 1'b1;
    step(0, 0);
    reset = 1'b0;
    n_iv = 0;
    chk("f_rv_rst", rate_valid, 0);
    chk("f_burst_rst", burst, 0);
    chk("f_rate_rst", rate_out, 0);
    for (int k = 0; k < 16; k++) begin
      step(k == 4 || k == 12, 0);
      if (k == 4) chk("f_niv_first", n_iv, 0);
      if (k == 12) begin
        chk("f_iv13", isi_valid, 1);
        chk("f_isi13", isi_out, 8);
      end
    end
    chk("f_rv16", rate_valid, 1);
    chk("f_rate16", rate_out, 2);
    chk("f_nrv", n_rv, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
